fpga: RTL and testbench

FPGA -- requirements
Module: fpga

---
 rtl/fpga.sv | 153 +++++++++++++++
 tb/tb_fpga.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga.sv
// Eight-cell LUT fabric: wired-OR switch boxes feed two chained LUTs and a flip-flop per cell.
// Define FPGA_OUT_GATE_EN to AND each output o_j with select.mem[j].

module fpga_cfg16 (
    input  logic        clock,
    output logic [15:0] q
);
    logic [15:0] configure;

    // Holds its contents; the word is loaded from outside by hierarchical assignment.
    always @(posedge clock) configure <= configure;
    assign q = configure;
endmodule

module fpga_cfg33 (
    input  logic        clock,
    output logic [32:0] q
);
    logic [32:0] mem;

    always @(posedge clock) mem <= mem;
    assign q = mem;
endmodule

module fpga (
    input  logic clock,
    input  logic clear,
    input  logic i0,
    input  logic i1,
    input  logic i2,
    input  logic i3,
    input  logic i4,
    input  logic i5,
    input  logic i6,
    input  logic i7,
    input  logic i8,
    input  logic i9,
    input  logic i10,
    input  logic i11,
    output logic o0,
    output logic o1,
    output logic o2,
    output logic o3,
    output logic o4,
    output logic o5,
    output logic o6,
    output logic o7,
    output logic o8
);
    logic [15:0] w_sba [8];
    logic [15:0] w_sbb [8];
    logic [15:0] w_sbc [8];
    logic [15:0] w_sbd [8];
    logic [15:0] w_sbe [9];
    logic [32:0] w_lta [8];
    logic [32:0] w_lt  [8];
    logic [32:0] w_select;
    logic [7:0]  w_in;
    logic [7:0]  w_q_prev;
    logic [7:0]  w_q_next;
    logic [7:0]  w_lt_out;
    logic [7:0]  w_cell;
    logic [15:0] w_gsrc;
    logic [8:0]  w_sbe_out;
    logic [8:0]  w_o;
    logic [7:0]  r_q;

    fpga_cfg16 sb0a (.clock(clock), .q(w_sba[0]));  fpga_cfg16 sb0b (.clock(clock), .q(w_sbb[0]));
    fpga_cfg16 sb0c (.clock(clock), .q(w_sbc[0]));  fpga_cfg16 sb0d (.clock(clock), .q(w_sbd[0]));
    fpga_cfg16 sb1a (.clock(clock), .q(w_sba[1]));  fpga_cfg16 sb1b (.clock(clock), .q(w_sbb[1]));
    fpga_cfg16 sb1c (.clock(clock), .q(w_sbc[1]));  fpga_cfg16 sb1d (.clock(clock), .q(w_sbd[1]));
    fpga_cfg16 sb2a (.clock(clock), .q(w_sba[2]));  fpga_cfg16 sb2b (.clock(clock), .q(w_sbb[2]));
    fpga_cfg16 sb2c (.clock(clock), .q(w_sbc[2]));  fpga_cfg16 sb2d (.clock(clock), .q(w_sbd[2]));
    fpga_cfg16 sb3a (.clock(clock), .q(w_sba[3]));  fpga_cfg16 sb3b (.clock(clock), .q(w_sbb[3]));
    fpga_cfg16 sb3c (.clock(clock), .q(w_sbc[3]));  fpga_cfg16 sb3d (.clock(clock), .q(w_sbd[3]));
    fpga_cfg16 sb4a (.clock(clock), .q(w_sba[4]));  fpga_cfg16 sb4b (.clock(clock), .q(w_sbb[4]));
    fpga_cfg16 sb4c (.clock(clock), .q(w_sbc[4]));  fpga_cfg16 sb4d (.clock(clock), .q(w_sbd[4]));
    fpga_cfg16 sb5a (.clock(clock), .q(w_sba[5]));  fpga_cfg16 sb5b (.clock(clock), .q(w_sbb[5]));
    fpga_cfg16 sb5c (.clock(clock), .q(w_sbc[5]));  fpga_cfg16 sb5d (.clock(clock), .q(w_sbd[5]));
    fpga_cfg16 sb6a (.clock(clock), .q(w_sba[6]));  fpga_cfg16 sb6b (.clock(clock), .q(w_sbb[6]));
    fpga_cfg16 sb6c (.clock(clock), .q(w_sbc[6]));  fpga_cfg16 sb6d (.clock(clock), .q(w_sbd[6]));
    fpga_cfg16 sb7a (.clock(clock), .q(w_sba[7]));  fpga_cfg16 sb7b (.clock(clock), .q(w_sbb[7]));
    fpga_cfg16 sb7c (.clock(clock), .q(w_sbc[7]));  fpga_cfg16 sb7d (.clock(clock), .q(w_sbd[7]));

    fpga_cfg16 sb0e (.clock(clock), .q(w_sbe[0]));  fpga_cfg16 sb1e (.clock(clock), .q(w_sbe[1]));
    fpga_cfg16 sb2e (.clock(clock), .q(w_sbe[2]));  fpga_cfg16 sb3e (.clock(clock), .q(w_sbe[3]));
    fpga_cfg16 sb4e (.clock(clock), .q(w_sbe[4]));  fpga_cfg16 sb5e (.clock(clock), .q(w_sbe[5]));
    fpga_cfg16 sb6e (.clock(clock), .q(w_sbe[6]));  fpga_cfg16 sb7e (.clock(clock), .q(w_sbe[7]));
    fpga_cfg16 sb8e (.clock(clock), .q(w_sbe[8]));

    fpga_cfg33 lta_0 (.clock(clock), .q(w_lta[0]));  fpga_cfg33 lt_0 (.clock(clock), .q(w_lt[0]));
    fpga_cfg33 lta_1 (.clock(clock), .q(w_lta[1]));  fpga_cfg33 lt_1 (.clock(clock), .q(w_lt[1]));
    fpga_cfg33 lta_2 (.clock(clock), .q(w_lta[2]));  fpga_cfg33 lt_2 (.clock(clock), .q(w_lt[2]));
    fpga_cfg33 lta_3 (.clock(clock), .q(w_lta[3]));  fpga_cfg33 lt_3 (.clock(clock), .q(w_lt[3]));
    fpga_cfg33 lta_4 (.clock(clock), .q(w_lta[4]));  fpga_cfg33 lt_4 (.clock(clock), .q(w_lt[4]));
    fpga_cfg33 lta_5 (.clock(clock), .q(w_lta[5]));  fpga_cfg33 lt_5 (.clock(clock), .q(w_lt[5]));
    fpga_cfg33 lta_6 (.clock(clock), .q(w_lta[6]));  fpga_cfg33 lt_6 (.clock(clock), .q(w_lt[6]));
    fpga_cfg33 lta_7 (.clock(clock), .q(w_lta[7]));  fpga_cfg33 lt_7 (.clock(clock), .q(w_lt[7]));

    fpga_cfg33 select (.clock(clock), .q(w_select));

    assign w_in = {i7, i6, i5, i4, i3, i2, i1, i0};
    // Neighbour taps; the chain ends wrap to global input i8 instead of each other.
    assign w_q_prev = {r_q[6:0], i8};
    assign w_q_next = {i8, r_q[7:1]};

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_cell
            logic [15:0] w_src;
            logic        w_ra;
            logic        w_rb;
            logic        w_rc;
            logic        w_rd;
            logic        w_lta_out;

            assign w_src = {6'b000000, i11, i10, i9, i8, r_q[gi], w_q_next[gi], w_q_prev[gi],
                            w_in[gi], 2'b10};
            assign w_ra = |(w_sba[gi] & w_src);
            assign w_rb = |(w_sbb[gi] & w_src);
            assign w_rc = |(w_sbc[gi] & w_src);
            assign w_rd = |(w_sbd[gi] & w_src);
            assign w_lta_out    = w_lta[gi][{2'b00, w_rd, w_rc, w_rb, w_ra}];
            assign w_lt_out[gi] = w_lt[gi][{1'b0, w_lta_out, w_rd, w_rc, w_rb, w_ra}];
            assign w_cell[gi]   = w_lt[gi][32] ? r_q[gi] : w_lt_out[gi];
        end

        assign w_gsrc = {3'b000, 1'b1, i11, i10, i9, i8, w_cell};
        for (gi = 0; gi < 9; gi++) begin : g_out
            assign w_sbe_out[gi] = |(w_sbe[gi] & w_gsrc);
        end
    endgenerate

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_q <= '0;
        end else begin
            r_q <= w_lt_out;
        end
    end

`ifdef FPGA_OUT_GATE_EN
    logic w_unused_select;
    assign w_unused_select = ^w_select[32:9];
    assign w_o = w_sbe_out & w_select[8:0];
`else
    logic w_unused_select;
    assign w_unused_select = ^w_select;
    assign w_o = w_sbe_out;
`endif

    assign {o8, o7, o6, o5, o4, o3, o2, o1, o0} = w_o;
endmodule

// File: tb/tb_fpga.sv
// Scoreboard bench for the fpga fabric: directed scenarios plus randomized configurations
// checked against a behavioural model of the source/LUT/output rules.
module tb_fpga;
    logic clock = 1'b0;
    logic clear = 1'b0;
    logic i0, i1, i2, i3, i4, i5, i6, i7, i8, i9, i10, i11;
    logic o0, o1, o2, o3, o4, o5, o6, o7, o8;

    always #5 clock = ~clock;

    fpga dut (
        .clock(clock), .clear(clear),
        .i0(i0), .i1(i1), .i2(i2), .i3(i3), .i4(i4), .i5(i5), .i6(i6), .i7(i7),
        .i8(i8), .i9(i9), .i10(i10), .i11(i11),
        .o0(o0), .o1(o1), .o2(o2), .o3(o3), .o4(o4), .o5(o5), .o6(o6), .o7(o7), .o8(o8)
    );

    logic [15:0] cfg_a [8];
    logic [15:0] cfg_b [8];
    logic [15:0] cfg_c [8];
    logic [15:0] cfg_d [8];
    logic [15:0] cfg_e [9];
    logic [32:0] mem_a [8];
    logic [32:0] mem_l [8];
    logic [32:0] sel;
    logic [7:0]  qm;
    logic [7:0]  nq_pending;

    typedef struct {
        logic [8:0] exp;
        string      name;
    } exp_t;
    exp_t sbq[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Cell source n as seen by cell k.
    function automatic logic src_bit(int k, int n, logic [11:0] in, logic [7:0] q);
        case (n)
            1:          return 1'b1;
            2:          return in[k];
            3:          return (k == 0) ? in[8] : q[k-1];
            4:          return (k == 7) ? in[8] : q[k+1];
            5:          return q[k];
            6, 7, 8, 9: return in[n+2];
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic box(logic [15:0] cfg, int k, logic [11:0] in, logic [7:0] q);
        logic r;
        r = 1'b0;
        for (int n = 0; n < 16; n++) if (cfg[n] && src_bit(k, n, in, q)) r = 1'b1;
        return r;
    endfunction

    function automatic logic lut_out(int k, logic [11:0] in, logic [7:0] q);
        int addr;
        int top;
        addr = 8 * int'(box(cfg_d[k], k, in, q)) + 4 * int'(box(cfg_c[k], k, in, q))
             + 2 * int'(box(cfg_b[k], k, in, q)) + int'(box(cfg_a[k], k, in, q));
        top  = int'(mem_a[k][addr]);
        return mem_l[k][16 * top + addr];
    endfunction

    function automatic logic [7:0] model_next(logic [11:0] in, logic [7:0] q);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[k] = lut_out(k, in, q);
        return r;
    endfunction

    function automatic logic [8:0] model_out(logic [11:0] in, logic [7:0] q);
        logic [7:0] c;
        logic [8:0] r;
        logic       g;
        for (int k = 0; k < 8; k++) c[k] = mem_l[k][32] ? q[k] : lut_out(k, in, q);
        for (int j = 0; j < 9; j++) begin
            r[j] = 1'b0;
            for (int n = 0; n < 16; n++) begin
                if (n < 8)       g = c[n];
                else if (n < 12) g = in[n];
                else             g = (n == 12);
                if (cfg_e[j][n] && g) r[j] = 1'b1;
            end
`ifdef FPGA_OUT_GATE_EN
            r[j] = r[j] & sel[j];
`endif
        end
        return r;
    endfunction

    task automatic apply_cfg();
        dut.sb0a.configure <= cfg_a[0]; dut.sb0b.configure <= cfg_b[0]; dut.sb0c.configure <= cfg_c[0]; dut.sb0d.configure <= cfg_d[0];
        dut.sb1a.configure <= cfg_a[1]; dut.sb1b.configure <= cfg_b[1]; dut.sb1c.configure <= cfg_c[1]; dut.sb1d.configure <= cfg_d[1];
        dut.sb2a.configure <= cfg_a[2]; dut.sb2b.configure <= cfg_b[2]; dut.sb2c.configure <= cfg_c[2]; dut.sb2d.configure <= cfg_d[2];
        dut.sb3a.configure <= cfg_a[3]; dut.sb3b.configure <= cfg_b[3]; dut.sb3c.configure <= cfg_c[3]; dut.sb3d.configure <= cfg_d[3];
        dut.sb4a.configure <= cfg_a[4]; dut.sb4b.configure <= cfg_b[4]; dut.sb4c.configure <= cfg_c[4]; dut.sb4d.configure <= cfg_d[4];
        dut.sb5a.configure <= cfg_a[5]; dut.sb5b.configure <= cfg_b[5]; dut.sb5c.configure <= cfg_c[5]; dut.sb5d.configure <= cfg_d[5];
        dut.sb6a.configure <= cfg_a[6]; dut.sb6b.configure <= cfg_b[6]; dut.sb6c.configure <= cfg_c[6]; dut.sb6d.configure <= cfg_d[6];
        dut.sb7a.configure <= cfg_a[7]; dut.sb7b.configure <= cfg_b[7]; dut.sb7c.configure <= cfg_c[7]; dut.sb7d.configure <= cfg_d[7];
        dut.lta_0.mem <= mem_a[0]; dut.lta_1.mem <= mem_a[1]; dut.lta_2.mem <= mem_a[2]; dut.lta_3.mem <= mem_a[3];
        dut.lta_4.mem <= mem_a[4]; dut.lta_5.mem <= mem_a[5]; dut.lta_6.mem <= mem_a[6]; dut.lta_7.mem <= mem_a[7];
        dut.lt_0.mem <= mem_l[0]; dut.lt_1.mem <= mem_l[1]; dut.lt_2.mem <= mem_l[2]; dut.lt_3.mem <= mem_l[3];
        dut.lt_4.mem <= mem_l[4]; dut.lt_5.mem <= mem_l[5]; dut.lt_6.mem <= mem_l[6]; dut.lt_7.mem <= mem_l[7];
        dut.sb0e.configure <= cfg_e[0]; dut.sb1e.configure <= cfg_e[1]; dut.sb2e.configure <= cfg_e[2];
        dut.sb3e.configure <= cfg_e[3]; dut.sb4e.configure <= cfg_e[4]; dut.sb5e.configure <= cfg_e[5];
        dut.sb6e.configure <= cfg_e[6]; dut.sb7e.configure <= cfg_e[7]; dut.sb8e.configure <= cfg_e[8];
        dut.select.mem <= sel;
    endtask

    task automatic cfg_common();
        for (int j = 0; j < 8; j++) cfg_e[j] = 16'(1 << j);
        cfg_e[8] = 16'h0100;
    endtask

    task automatic cfg_comb();
        for (int k = 0; k < 8; k++) begin
            cfg_a[k] = 16'h0004; cfg_b[k] = 16'h0000; cfg_c[k] = 16'h0000; cfg_d[k] = 16'h0000;
            mem_a[k] = 33'h0; mem_l[k] = 33'h0AAAAAAAA;
        end
        cfg_common();
    endtask

    task automatic cfg_reg();
        for (int k = 0; k < 8; k++) begin
            cfg_a[k] = 16'h0004; cfg_b[k] = 16'h0008; cfg_c[k] = 16'h0200; cfg_d[k] = 16'h0000;
            mem_a[k] = 33'h0; mem_l[k] = 33'h1ACACACAC;
        end
        cfg_common();
    endtask

    task automatic cfg_random();
        for (int k = 0; k < 8; k++) begin
            cfg_a[k] = 16'($urandom & $urandom & $urandom);
            cfg_b[k] = 16'($urandom & $urandom & $urandom);
            cfg_c[k] = 16'($urandom & $urandom & $urandom);
            cfg_d[k] = 16'($urandom & $urandom & $urandom);
            mem_a[k] = {1'($urandom_range(0, 1)), 32'($urandom)};
            mem_l[k] = {1'($urandom_range(0, 1)), 32'($urandom)};
        end
        for (int j = 0; j < 9; j++) cfg_e[j] = 16'($urandom & $urandom);
        sel = {1'($urandom_range(0, 1)), 32'($urandom)};
    endtask

    // One clock cycle: after the edge, apply config and inputs, then queue the expectation
    // for the sample taken before the following edge.
    task automatic cycle(input logic [11:0] in_v, input logic clr, input logic use_model,
                         input logic [8:0] exp_v, input string name);
        exp_t e;
        @(posedge clock);
        qm = nq_pending;
        #1;
        apply_cfg();
        {i11, i10, i9, i8, i7, i6, i5, i4, i3, i2, i1, i0} = in_v;
        clear = clr;
        if (clr) qm = 8'h00;
        e.exp  = use_model ? model_out(in_v, qm) : exp_v;
        e.name = name;
        sbq.push_back(e);
        nq_pending = clr ? 8'h00 : model_next(in_v, qm);
    endtask

    initial begin : monitor
        exp_t       e;
        logic [8:0] got;
        forever begin
            @(negedge clock);
            if (sbq.size() > 0) begin
                e   = sbq.pop_front();
                got = {o8, o7, o6, o5, o4, o3, o2, o1, o0};
                n_tests++;
                if (got !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: o=%03h required %03h", e.name, got, e.exp);
                end else begin
                    $display("[TB] %s: o=%03h", e.name, got);
                end
            end
        end
    end

    initial begin : stimulus
        logic [11:0] iv;
        logic        cv;
        {i11, i10, i9, i8, i7, i6, i5, i4, i3, i2, i1, i0} = 12'h000;
`ifdef FPGA_OUT_GATE_EN
        sel = 33'h1FF;
`else
        sel = 33'h000;
`endif
        qm = 8'h00;
        nq_pending = 8'h00;
        cfg_reg();
        apply_cfg();
        #1 clear = 1'b1;

        cycle(12'h9FF, 1'b1, 1'b0, 9'h100, "clear_holds_q");
        cycle(12'h9FF, 1'b1, 1'b0, 9'h100, "clear_held");
        cfg_comb();
        cycle(12'h1AD, 1'b1, 1'b0, 9'h1AD, "comb_pass_AD");
        cycle(12'h052, 1'b1, 1'b0, 9'h052, "comb_pass_52");
        cfg_reg();
        cycle(12'h8AD, 1'b0, 1'b0, 9'h000, "load_setup");
        cycle(12'h1AD, 1'b0, 1'b0, 9'h1AD, "reg_load_AD");
        cycle(12'h0AD, 1'b0, 1'b0, 9'h05B, "shift_in_1");
        cycle(12'h0AD, 1'b0, 1'b0, 9'h0B6, "shift_in_0");
        cycle(12'h8FF, 1'b1, 1'b0, 9'h000, "async_clear");
        cycle(12'h8FF, 1'b0, 1'b0, 9'h000, "clear_release");
        cycle(12'h8FF, 1'b0, 1'b0, 9'h0FF, "reload_FF");

        cfg_comb();
        cfg_e[8] = 16'h1000;
        sel = 33'h0FF;
`ifdef FPGA_OUT_GATE_EN
        cycle(12'h03C, 1'b0, 1'b0, 9'h03C, "gate_sel_0FF");
`else
        cycle(12'h03C, 1'b0, 1'b0, 9'h13C, "gate_sel_0FF");
`endif
        sel = 33'h1FF;
        cycle(12'h03C, 1'b0, 1'b0, 9'h13C, "gate_sel_1FF");

        for (int blk = 0; blk < 10; blk++) begin
            cfg_random();
            for (int t = 0; t < 20; t++) begin
                iv = 12'($urandom);
                cv = ($urandom_range(0, 15) == 0);
                cycle(iv, cv, 1'b1, 9'h000, "random");
            end
        end

        @(negedge clock);
        #1;
        if (sbq.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d pending, required 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
